// File: rtl/reg_box_scan_renderer.sv
// reg_box_scan_renderer: full-frame scan renderer that draws a row of register
// boxes into a vga_adapter pixel-write port. One pixel is emitted per clock, so
// the whole frame is repainted on every sweep.
//
// Each box gets an outline. Its interior is filled when the matching bit of a
// highlight mask is set. The mask is snapshotted at the start of each frame, so
// a change in the middle of a frame can never tear the image.
//
// Optional build macro: RENDER_GRID_EN. When it is defined, background pixels
// on every 32nd column and row are drawn in a grid colour. When it is not
// defined, no grid logic is generated.

module reg_box_scan_renderer #(
    parameter int         NUM_BOXES  = 8,
    parameter int         BOX_SIZE   = 32,
    parameter int         X_FIRST    = 40,
    parameter int         X_PITCH    = 80,
    parameter int         Y_CENTER   = 240,
    parameter int         H_RES      = 640,
    parameter int         V_RES      = 480,
    parameter logic [8:0] LINE_COLOR = 9'h1FF,
    parameter logic [8:0] FILL_COLOR = 9'h007,
    parameter logic [8:0] BG_COLOR   = 9'h000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 hold,
    input  logic [NUM_BOXES-1:0] highlight,
    output logic [9:0]           draw_x,
    output logic [8:0]           draw_y,
    output logic [8:0]           pixel_color,
    output logic                 write,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    localparam int HALF = BOX_SIZE / 2;

    // Vertical extent shared by every box. The box spans 2*HALF rows.
    localparam logic signed [12:0] Y_TOP = 13'(Y_CENTER - HALF);
    localparam logic signed [12:0] Y_BOT = 13'(Y_CENTER + HALF - 1);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

`ifdef RENDER_GRID_EN
    localparam logic [8:0] GRID_COLOR = 9'h049;
`endif

    state_e               state;
    logic [9:0]           cx;
    logic [8:0]           cy;
    logic [NUM_BOXES-1:0] hl_snap;

    // Signed, widened copies of the counters. Box edges near x=0 can then go
    // negative without wrapping.
    logic signed [12:0] cx_s;
    logic signed [12:0] cy_s;

    assign cx_s = $signed({3'b000, cx});
    assign cy_s = $signed({4'b0000, cy});

    // Row-level terms are identical for every box, so they are computed once.
    logic on_hline;
    logic in_y_closed;
    logic in_y_open;

    assign on_hline    = (cy_s == Y_TOP) || (cy_s == Y_BOT);
    assign in_y_closed = (cy_s >= Y_TOP) && (cy_s <= Y_BOT);
    assign in_y_open   = (cy_s > Y_TOP) && (cy_s < Y_BOT);

    logic [NUM_BOXES-1:0] box_edge;
    logic [NUM_BOXES-1:0] box_inner;

    for (genvar k = 0; k < NUM_BOXES; k++) begin : g_box
        localparam int               XC     = X_FIRST + k * X_PITCH;
        localparam logic signed [12:0] X_LEFT = 13'(XC - HALF);
        localparam logic signed [12:0] X_RGHT = 13'(XC + HALF);

        logic in_x_closed;
        logic in_x_open;
        logic on_vline;

        assign in_x_closed  = (cx_s >= X_LEFT) && (cx_s <= X_RGHT);
        assign in_x_open    = (cx_s > X_LEFT) && (cx_s < X_RGHT);
        assign on_vline     = (cx_s == X_LEFT) || (cx_s == X_RGHT);
        assign box_edge[k]  = (on_hline && in_x_closed) || (on_vline && in_y_closed);
        assign box_inner[k] = in_x_open && in_y_open;
    end

`ifdef RENDER_GRID_EN
    logic on_grid;

    assign on_grid = (cx[4:0] == 5'd0) || (cy[4:0] == 5'd0);
`endif

    logic [8:0] color_d;

    // Pixel colour for the current counter position. An outline wins over a
    // fill, and any box pixel wins over the grid or the background.
    always_comb begin
        color_d = BG_COLOR;
        if (|box_edge) begin
            color_d = LINE_COLOR;
        end else if (|(box_inner & hl_snap)) begin
            color_d = FILL_COLOR;
`ifdef RENDER_GRID_EN
        end else if (!(|box_inner) && on_grid) begin
            color_d = GRID_COLOR;
`endif
        end
    end

    // Sweep FSM: scan counters, highlight snapshot and all registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= StIdle;
            cx          <= '0;
            cy          <= '0;
            hl_snap     <= '0;
            draw_x      <= '0;
            draw_y      <= '0;
            pixel_color <= '0;
            write       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    write      <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    if (start || continuous) begin
                        state   <= StSweep;
                        cx      <= '0;
                        cy      <= '0;
                        hl_snap <= highlight;
                        busy    <= 1'b1;
                    end
                end

                StSweep: begin
                    frame_done <= 1'b0;
                    if (hold) begin
                        // Stall: drop the strobe and keep the last pixel on the bus.
                        write <= 1'b0;
                    end else begin
                        draw_x      <= cx;
                        draw_y      <= cy;
                        pixel_color <= color_d;
                        write       <= 1'b1;
                        if (cx == X_LAST) begin
                            cx <= '0;
                            if (cy == Y_LAST) begin
                                cy    <= '0;
                                state <= StDone;
                            end else begin
                                cy <= cy + 9'd1;
                            end
                        end else begin
                            cx <= cx + 10'd1;
                        end
                    end
                end

                StDone: begin
                    // The last pixel was written on entry. Signal the frame end
                    // and either rearm or go idle. hold has no effect here.
                    write      <= 1'b0;
                    frame_done <= 1'b1;
                    cx         <= '0;
                    cy         <= '0;
                    if (continuous) begin
                        state   <= StSweep;
                        hl_snap <= highlight;
                        busy    <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    write <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
